// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit scheduler: FSM encoding, source
// indices and the default bandscope frame length.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int N_SRC  = 3;
  localparam int SRC_RX = 0;
  localparam int SRC_ST = 1;
  localparam int SRC_BS = 2;

  localparam int BS_PKTS_DEFAULT = 67;

endpackage

// File: rtl/usb_prio_pick.sv
// Fixed-priority picker RX > status > BS, with RX optionally masked out so a
// starved source can win one arbitration.
module usb_prio_pick
  import usb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic             rx_mask,
  output logic [N_SRC-1:0] winner
);

  logic [N_SRC-1:0] eligible;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    eligible         = req;
    eligible[SRC_RX] = req[SRC_RX] & ~rx_mask;
    winner           = '0;
    if (eligible[SRC_RX])      winner[SRC_RX] = 1'b1;
    else if (eligible[SRC_ST]) winner[SRC_ST] = 1'b1;
    else if (eligible[SRC_BS]) winner[SRC_BS] = 1'b1;
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates the FT-FIFO transmit path between RX IQ, status and bandscope
// packets, with inter-packet gap, RX starvation guard and a stuck-grant watchdog.
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int MAX_RX_BURST = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 2048,
  parameter int TO_W         = 12,
  parameter int BS_PKTS      = BS_PKTS_DEFAULT
) (
  input  logic       usb_clock,
  input  logic       reset,
  input  logic       n_TXE,
  input  logic       rx_req,
  input  logic       bs_req,
  input  logic       st_req,
  input  logic       rx_done,
  input  logic       bs_done,
  input  logic       st_done,
  input  logic       err_clr,
  output logic       rx_gnt,
  output logic       bs_gnt,
  output logic       st_gnt,
  output logic [7:0] bs_pn,
  output logic       bs_frame_done,
  output logic       timeout_err,
  output logic       busy
);

  localparam int STREAK_W = $clog2(MAX_RX_BURST + 1);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RX_BURST);
  localparam logic [TO_W-1:0]     WD_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]          PN_LAST    = 8'(BS_PKTS - 1);

  state_t              state;
  logic [N_SRC-1:0]    gnt;
  logic [N_SRC-1:0]    req;
  logic [N_SRC-1:0]    done_vec;
  logic [N_SRC-1:0]    winner;
  logic [STREAK_W-1:0] rx_streak;
  logic [TO_W-1:0]     wd_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                others_pending;
  logic                rx_mask;
  logic                done_hit;

  always_comb begin
    req              = '0;
    req[SRC_RX]      = rx_req;
    req[SRC_ST]      = st_req;
    req[SRC_BS]      = bs_req;
    done_vec         = '0;
    done_vec[SRC_RX] = rx_done;
    done_vec[SRC_ST] = st_done;
    done_vec[SRC_BS] = bs_done;
  end

  assign others_pending = st_req | bs_req;
  assign rx_mask        = (rx_streak == STREAK_MAX) & others_pending;
  // Only the owner's done counts; strays from other sources fall out here.
  assign done_hit       = |(gnt & done_vec);

  usb_prio_pick u_pick (
    .req     (req),
    .rx_mask (rx_mask),
    .winner  (winner)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge usb_clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      gnt           <= '0;
      busy          <= 1'b0;
      rx_streak     <= '0;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
      bs_pn         <= '0;
      bs_frame_done <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      bs_frame_done <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!n_TXE && (|req)) begin
            gnt    <= winner;
            busy   <= 1'b1;
            state  <= BUSY;
            wd_cnt <= '0;
            if (winner[SRC_RX] && others_pending) begin
              if (rx_streak != STREAK_MAX) rx_streak <= rx_streak + 1'b1;
            end else begin
              rx_streak <= '0;
            end
          end
        end

        BUSY: begin
          if (done_hit || (wd_cnt == WD_LAST)) begin
            gnt     <= '0;
            wd_cnt  <= '0;
            gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
            if (!done_hit) begin
              timeout_err <= 1'b1;
            end else if (gnt[SRC_BS]) begin
              if (bs_pn == PN_LAST) begin
                bs_pn         <= '0;
                bs_frame_done <= 1'b1;
              end else begin
                bs_pn <= bs_pn + 8'd1;
              end
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_gnt = gnt[SRC_RX];
  assign st_gnt = gnt[SRC_ST];
  assign bs_gnt = gnt[SRC_BS];

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: latency/gap, RX starvation guard,
// bandscope numbering, watchdog, FIFO-full hold-off and async reset.
module tb_usb_tx_scheduler;

  logic       usb_clock = 1'b0;
  logic       reset;
  logic       n_TXE;
  logic       rx_req, bs_req, st_req;
  logic       rx_done, bs_done, st_done;
  logic       err_clr;
  logic       rx_gnt, bs_gnt, st_gnt;
  logic [7:0] bs_pn;
  logic       bs_frame_done;
  logic       timeout_err;
  logic       busy;

  logic [2:0] gnt_v;
  assign gnt_v = {bs_gnt, st_gnt, rx_gnt};

  localparam logic [2:0] G_RX = 3'b001;
  localparam logic [2:0] G_ST = 3'b010;
  localparam logic [2:0] G_BS = 3'b100;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_pn    = 0;

  usb_tx_scheduler dut (
    .usb_clock     (usb_clock),
    .reset         (reset),
    .n_TXE         (n_TXE),
    .rx_req        (rx_req),
    .bs_req        (bs_req),
    .st_req        (st_req),
    .rx_done       (rx_done),
    .bs_done       (bs_done),
    .st_done       (st_done),
    .err_clr       (err_clr),
    .rx_gnt        (rx_gnt),
    .bs_gnt        (bs_gnt),
    .st_gnt        (st_gnt),
    .bs_pn         (bs_pn),
    .bs_frame_done (bs_frame_done),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  always #5 usb_clock = ~usb_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge usb_clock);
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp);
    int n = 0;
    while (gnt_v == 3'b000 && n < 20) begin
      tick();
      n++;
    end
    check(tag, gnt_v, exp);
  endtask

  task automatic pulse_done();
    rx_done = rx_gnt;
    st_done = st_gnt;
    bs_done = bs_gnt;
    tick();
    rx_done = 1'b0;
    st_done = 1'b0;
    bs_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || gnt_v != 3'b000) && n < 3000) begin
      tick();
      n++;
    end
    check("idle", {gnt_v, busy}, 4'b0000);
  endtask

  task automatic grant_len(output int len);
    len = 0;
    while (gnt_v != 3'b000 && len < 3000) begin
      tick();
      len++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, gnt_v, 3'b000);
    check({tag, "_pn"}, bs_pn, 8'd0);
    check({tag, "_flags"}, {bs_frame_done, timeout_err, busy}, 3'b000);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int len;
    int gcnt;
    logic [2:0] order [10];

    reset = 1'b0;
    n_TXE = 1'b0;
    {rx_req, bs_req, st_req}    = 3'b000;
    {rx_done, bs_done, st_done} = 3'b000;
    err_clr = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // RX streaming: 1-cycle grant latency, done 10 cycles in, 2 gap cycles + 1 idle.
    rx_req = 1'b1;
    check("rx_lat0", gnt_v, 3'b000);
    tick();
    check("rx_lat1", {gnt_v, busy}, {G_RX, 1'b1});
    for (int k = 0; k < 3; k++) begin
      repeat (9) tick();
      check("rx_hold", {gnt_v, busy}, {G_RX, 1'b1});
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      check("rx_gap0", {gnt_v, busy}, 4'b0001);
      tick();
      check("rx_gap1", {gnt_v, busy}, 4'b0001);
      tick();
      check("rx_idle", {gnt_v, busy}, 4'b0000);
      tick();
      check("rx_regrant", {gnt_v, busy}, {G_RX, 1'b1});
    end
    rx_req = 1'b0;
    pulse_done();
    wait_idle();

    // RX starvation guard: four RX, then BS, and the streak restarts.
    order = '{G_RX, G_RX, G_RX, G_RX, G_BS, G_RX, G_RX, G_RX, G_RX, G_BS};
    rx_req = 1'b1;
    bs_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_grant("burst_order", order[i]);
      pulse_done();
    end
    rx_req = 1'b0;
    bs_req = 1'b0;
    check("burst_pn", bs_pn, 8'd2);
    wait_idle();

    // Full bandscope frame from a clean reset.
    do_reset();
    bs_req = 1'b1;
    exp_pn = 0;
    for (int i = 0; i < 67; i++) begin
      wait_grant("bs_gnt", G_BS);
      check("bs_pn_pre", bs_pn, exp_pn);
      pulse_done();
      check("bs_frame_done", bs_frame_done, (exp_pn == 66));
      exp_pn = (exp_pn == 66) ? 0 : exp_pn + 1;
      check("bs_pn_post", bs_pn, exp_pn);
    end
    bs_req = 1'b0;
    tick();
    check("bs_frame_pulse", bs_frame_done, 1'b0);
    wait_idle();

    // Watchdog on RX; request drop mid-grant must not end it.
    rx_req = 1'b1;
    wait_grant("to_rx_gnt", G_RX);
    rx_req = 1'b0;
    grant_len(len);
    check("to_rx_len", len, 2048);
    check("to_rx_err", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", timeout_err, 1'b0);
    wait_idle();

    // done on the very cycle the watchdog expires wins.
    rx_req = 1'b1;
    wait_grant("co_gnt", G_RX);
    rx_req = 1'b0;
    repeat (2047) tick();
    check("co_still", gnt_v, G_RX);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("co_drop", {gnt_v, timeout_err}, 4'b0000);
    wait_idle();

    // One good BS packet, then a BS timeout with err_clr held: pn stays, set wins.
    bs_req = 1'b1;
    wait_grant("bs1_gnt", G_BS);
    bs_req = 1'b0;
    pulse_done();
    exp_pn = 1;
    check("bs1_pn", bs_pn, exp_pn);
    wait_idle();
    err_clr = 1'b1;
    bs_req  = 1'b1;
    wait_grant("to_bs_gnt", G_BS);
    bs_req = 1'b0;
    grant_len(len);
    err_clr = 1'b0;
    check("to_bs_len", len, 2048);
    check("to_bs_err", timeout_err, 1'b1);
    check("to_bs_pn", bs_pn, exp_pn);
    wait_idle();

    // FIFO full holds off all grants; then RX wins and stray dones are ignored.
    n_TXE = 1'b1;
    {rx_req, bs_req, st_req} = 3'b111;
    gcnt = 0;
    repeat (50) begin
      tick();
      if (gnt_v != 3'b000) gcnt++;
    end
    check("txe_hold", gcnt, 0);
    n_TXE = 1'b0;
    tick();
    check("txe_grant", gnt_v, G_RX);
    bs_done = 1'b1;
    st_done = 1'b1;
    tick();
    bs_done = 1'b0;
    st_done = 1'b0;
    check("stray_gnt", gnt_v, G_RX);
    check("stray_pn", bs_pn, exp_pn);
    {rx_req, bs_req, st_req} = 3'b000;
    pulse_done();
    check("stray_end", gnt_v, 3'b000);
    wait_idle();

    // Status-only arbitration.
    st_req = 1'b1;
    wait_grant("st_gnt", G_ST);
    st_req = 1'b0;
    pulse_done();
    wait_idle();

    // Async reset mid-BUSY drops the grant before the next clock edge.
    rx_req = 1'b1;
    wait_grant("ar_gnt", G_RX);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("ar_async");
    rx_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("ar_rel");
    rx_req = 1'b1;
    tick();
    check("ar_restart", {gnt_v, busy}, {G_RX, 1'b1});
    rx_req = 1'b0;
    pulse_done();
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
